// File: rtl/mul89_pkg.sv
// Shared constants and state encoding for the 89x89 Fp multiplier datapath.
package mul89_pkg;

    localparam int unsigned OP_W     = 89;
    localparam int unsigned PP_W     = 178;
    localparam int unsigned N_ROWS   = 89;
    localparam int unsigned PP_BUS_W = N_ROWS * PP_W;   // 15842
    // Row index must hold up to (N_ITER*RPC) <= 177.
    localparam int unsigned IDX_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pp_slice_adder.sv
// Combinational sum of ROWS_PER_CYCLE consecutive 178-bit partial-product rows
// starting at row_idx; rows at index >= N_ROWS contribute zero.
// Ports:
//   pp_flat     : flattened partial-product matrix, row k at [178k+177:178k]
//   row_idx     : first row of this slice
//   slice_sum_c : slice sum truncated to 178 bits
module pp_slice_adder
    import mul89_pkg::*;
#(
    parameter int unsigned ROWS_PER_CYCLE = 8
) (
    input  logic [PP_BUS_W-1:0] pp_flat,
    input  logic [IDX_W-1:0]    row_idx,
    output logic [PP_W-1:0]     slice_sum_c
);

    localparam int unsigned SUM_W = PP_W + $clog2(ROWS_PER_CYCLE);

    logic [SUM_W-1:0] sum_full;

    // Full-width slice sum; the top bits are dropped since the accumulator is 178 bits.
    always_comb begin
        sum_full = '0;
        for (int unsigned j = 0; j < ROWS_PER_CYCLE; j++) begin
            if ((32'(row_idx) + j) < N_ROWS) begin
                sum_full = sum_full + SUM_W'(pp_flat[(32'(row_idx) + j) * PP_W +: PP_W]);
            end
        end
        slice_sum_c = sum_full[PP_W-1:0];
    end

endmodule

// File: rtl/pp_row_accumulator_89x89.sv
// Iterative reduction of the 89-row partial-product matrix to the 178-bit product.
// Captures the matrix once, then adds ROWS_PER_CYCLE rows per clock into an accumulator.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   pp_in, in_valid      : partial-product matrix input with valid
//   in_ready             : high in IDLE
//   prod, out_valid      : product and valid (held in DONE until out_ready)
//   out_ready            : downstream accept
//   busy                 : high in ACC or DONE
module pp_row_accumulator_89x89
    import mul89_pkg::*;
#(
    parameter int unsigned ROWS_PER_CYCLE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PP_BUS_W-1:0] pp_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PP_W-1:0]     prod,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int unsigned N_ITER   = (N_ROWS + ROWS_PER_CYCLE - 1) / ROWS_PER_CYCLE;
    // row_idx value on the final accumulate cycle
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((N_ITER - 1) * ROWS_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(ROWS_PER_CYCLE);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    row_idx_q, row_idx_d;
    logic [PP_W-1:0]     acc_q, acc_d;
    logic [PP_BUS_W-1:0] pp_reg_q, pp_reg_d;
    logic [PP_W-1:0]     prod_q, prod_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [PP_W-1:0]     slice_sum_c;

    pp_slice_adder #(
        .ROWS_PER_CYCLE (ROWS_PER_CYCLE)
    ) u_slice_adder (
        .pp_flat     (pp_reg_q),
        .row_idx     (row_idx_q),
        .slice_sum_c (slice_sum_c)
    );

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_idx_q   <= '0;
            acc_q       <= '0;
            pp_reg_q    <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            acc_q       <= acc_d;
            pp_reg_q    <= pp_reg_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        acc_d       = acc_q;
        pp_reg_d    = pp_reg_q;
        prod_d      = prod_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    pp_reg_d  = pp_in;
                    acc_d     = '0;
                    row_idx_d = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                acc_d     = acc_q + slice_sum_c;
                row_idx_d = row_idx_q + IDX_STEP;
                if (row_idx_q == LAST_IDX) begin
                    // Load the result register together with the final accumulate.
                    prod_d  = acc_q + slice_sum_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs reflect the state being entered so they line up with state_q.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign prod      = prod_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pp_row_accumulator_89x89.sv
// Bench for pp_row_accumulator_89x89: three instances (RPC = 1, 8, 89) share the
// input bus; a transaction-level model predicts each instance's outputs every cycle.
module tb_pp_row_accumulator_89x89;
    import mul89_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [PP_BUS_W-1:0] pp_in = '0;
    logic                in_valid = 1'b0;
    logic                out_ready_v [3];
    logic                in_ready_v  [3];
    logic                out_valid_v [3];
    logic                busy_v      [3];
    logic [PP_W-1:0]     prod_v      [3];
    logic [OP_W-1:0]     cur_a = '0;
    logic [OP_W-1:0]     cur_b = '0;
    logic                check_en = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    always #5 clk = ~clk;

    pp_row_accumulator_89x89 #(.ROWS_PER_CYCLE(1)) u_rpc1 (
        .clk(clk), .rst_n(rst_n), .pp_in(pp_in), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .prod(prod_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .busy(busy_v[0]));
    pp_row_accumulator_89x89 #(.ROWS_PER_CYCLE(8)) u_rpc8 (
        .clk(clk), .rst_n(rst_n), .pp_in(pp_in), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .prod(prod_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .busy(busy_v[1]));
    pp_row_accumulator_89x89 #(.ROWS_PER_CYCLE(89)) u_rpc89 (
        .clk(clk), .rst_n(rst_n), .pp_in(pp_in), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .prod(prod_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .busy(busy_v[2]));

    function automatic int unsigned n_iter(int k);
        case (k)
            0:       return 89;
            1:       return 12;
            default: return 1;
        endcase
    endfunction

    // Partial-product matrix exactly as the AND matrix produces it.
    function automatic logic [PP_BUS_W-1:0] build_pp(logic [OP_W-1:0] a, logic [OP_W-1:0] b);
        logic [PP_BUS_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(N_ROWS); k++) begin
            if (b[k]) r[k*PP_W +: PP_W] = PP_W'(a) << k;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [PP_W-1:0] act, logic [PP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction model: idle / busy for n_iter cycles / holding result.
    int              m_phase [3] = '{0, 0, 0};
    int unsigned     m_cnt   [3] = '{0, 0, 0};
    logic [PP_W-1:0] m_exp   [3];
    logic [PP_W-1:0] m_prod  [3] = '{'0, '0, '0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_phase[k] = 0;
                m_prod[k]  = '0;
            end else begin
                case (m_phase[k])
                    0: if (in_valid) begin
                        m_phase[k] = 1;
                        m_cnt[k]   = n_iter(k);
                        m_exp[k]   = PP_W'(cur_a) * PP_W'(cur_b);
                    end
                    1: begin
                        m_cnt[k] = m_cnt[k] - 1;
                        if (m_cnt[k] == 0) begin
                            m_phase[k] = 2;
                            m_prod[k]  = m_exp[k];
                        end
                    end
                    default: if (out_ready_v[k]) m_phase[k] = 0;
                endcase
            end
        end
    end

    // Per-cycle compare of all instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("in_ready[%0d]", k),  PP_W'(in_ready_v[k]),  PP_W'(m_phase[k] == 0));
                chk($sformatf("out_valid[%0d]", k), PP_W'(out_valid_v[k]), PP_W'(m_phase[k] == 2));
                chk($sformatf("busy[%0d]", k),      PP_W'(busy_v[k]),      PP_W'(m_phase[k] != 0));
                chk($sformatf("prod[%0d]", k),      prod_v[k],             m_prod[k]);
            end
        end
    end

    // All tasks start and end at posedge+2.
    task automatic apply(logic [OP_W-1:0] a, logic [OP_W-1:0] b);
        cur_a    = a;
        cur_b    = b;
        pp_in    = build_pp(a, b);
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        pp_in    = {PP_BUS_W{1'b1}};
    endtask

    task automatic wait_main_valid(output int lat);
        lat = 1;
        while (out_valid_v[1] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic run_main(string name, logic [OP_W-1:0] a, logic [OP_W-1:0] b, logic [PP_W-1:0] exp);
        int lat;
        apply(a, b);
        wait_main_valid(lat);
        chk({name, "_latency"}, PP_W'(lat), PP_W'(13));
        chk({name, "_prod"}, prod_v[1], exp);
        @(posedge clk);
        #2;
    endtask

    task automatic check_main_reset(string name);
        chk({name, "_in_ready"},  PP_W'(in_ready_v[1]),  PP_W'(1));
        chk({name, "_out_valid"}, PP_W'(out_valid_v[1]), PP_W'(0));
        chk({name, "_busy"},      PP_W'(busy_v[1]),      PP_W'(0));
        chk({name, "_prod"},      prod_v[1],             PP_W'(0));
    endtask

    task automatic wait_all_idle();
        int t = 0;
        while (!(m_phase[0] == 0 && m_phase[1] == 0 && m_phase[2] == 0) && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("idle_wait_timeout", PP_W'(t < 500), PP_W'(1));
    endtask

    initial begin
        logic [OP_W-1:0] amax;
        logic [PP_W-1:0] maxsq;
        int lat;
        amax  = '1;
        maxsq = '1;
        maxsq = maxsq - (PP_W'(1) << 90) + PP_W'(2);   // 2^178 - 2^90 + 1
        for (int k = 0; k < 3; k++) out_ready_v[k] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_main_reset("reset");
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;

        run_main("one_by_one", 89'd1, 89'd1, PP_W'(1));
        wait_all_idle();
        run_main("max_by_max", amax, amax, maxsq);
        wait_all_idle();
        run_main("b_zero", amax, 89'd0, PP_W'(0));
        wait_all_idle();
        run_main("last_row", 89'd1, OP_W'(1) << 88, PP_W'(1) << 88);
        wait_all_idle();

        // Hold the result 20 cycles with out_ready low and in_valid asserted.
        out_ready_v[1] = 1'b0;
        apply(89'd7, 89'd9);
        wait_main_valid(lat);
        chk("stall_latency", PP_W'(lat), PP_W'(13));
        cur_a    = 89'd100;
        cur_b    = 89'd100;
        pp_in    = build_pp(cur_a, cur_b);
        in_valid = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #2;
        end
        chk("stall_prod", prod_v[1], PP_W'(63));
        chk("stall_out_valid", PP_W'(out_valid_v[1]), PP_W'(1));
        chk("stall_in_ready", PP_W'(in_ready_v[1]), PP_W'(0));
        in_valid       = 1'b0;
        out_ready_v[1] = 1'b1;
        @(posedge clk);
        #2;
        chk("release_in_ready", PP_W'(in_ready_v[1]), PP_W'(1));
        chk("release_out_valid", PP_W'(out_valid_v[1]), PP_W'(0));
        run_main("back_to_back", 89'd3, 89'd5, PP_W'(15));
        wait_all_idle();

        // Reset during the fifth accumulate cycle.
        apply(89'h155_5555_5555_5555_5555_5555, 89'h133_3333_3333_3333_3333_3333);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_main_reset("mid_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_main("after_reset", 89'd12345, 89'd6789, PP_W'(83810205));
        wait_all_idle();

        // Random sweep across all three instances.
        for (int n = 0; n < 400; n++) begin
            apply(OP_W'({$urandom, $urandom, $urandom}), OP_W'({$urandom, $urandom, $urandom}));
            wait_all_idle();
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
